mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (read-only) and the load/store requester of the pipeline.
- Sits between Control/InstructionMemory-side fetch logic, the Memory-stage data access, and a single memory port with variable latency.
- Data accesses have fixed priority, with a starvation counter that guarantees forward progress for fetch.
- Also supports a fetch flush so that branch redirects can cancel an in-flight fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width; byte-strobe width is DATA_W/8.
- STARVE_LIMIT, 3, consecutive data grants allowed while a fetch waits; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  cancels a pending or in-flight fetch.
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held with its qualifiers stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  DATA_W/8  store byte enables.
- d_ack  out  1  one-cycle pulse; d_rdata valid on loads.
- d_rdata  out  DATA_W  load data.
- mem_valid  out  1  memory request; held until mem_ready.
- mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields.
- mem_ready  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async, any cycle): state IDLE, starve_cnt 0, flush_pend 0.
  - All outputs 0: mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, if_ack, d_ack, if_rdata, d_rdata.
  - An in-flight memory transaction is abandoned; the memory must tolerate mem_valid dropping.
- FSM states:
  - IDLE, BUSY_I, BUSY_D.
  - IDLE -> BUSY_I on a fetch grant.
  - IDLE -> BUSY_D on a data grant.
  - BUSY_x -> IDLE on mem_ready.
- Request masking: in IDLE, a requester whose ack is high this cycle is treated as not requesting. This prevents re-granting a held request.
- Arbitration (IDLE only), using masked requests:
  - Fetch is suppressed if if_flush=1.
  - Only data pending -> grant data.
  - Only fetch pending -> grant fetch.
  - Both pending -> grant data if starve_cnt < STARVE_LIMIT, otherwise grant fetch.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each data grant while an unmasked, unflushed fetch is pending.
  - Clears to 0 on any fetch grant.
- Grant timing:
  - A grant in cycle N registers mem_valid=1 and the mem_* fields at edge N+1.
  - In BUSY_x, mem_* fields stay stable and mem_valid stays 1 until mem_ready.
- Completion timing:
  - mem_ready in cycle M clears mem_valid and returns the FSM to IDLE at edge M+1.
  - The matching ack pulses in cycle M+1, with rdata registered from mem_rdata.
  - Minimum request-to-ack latency is 2 cycles (mem_ready in the first valid cycle).
  - A new grant can be made in cycle M+1, so back-to-back transfers take one idle-bus cycle each.
- Fetch flush:
  - if_flush in BUSY_I sets flush_pend. The transaction still completes on the memory side; if_ack is suppressed and flush_pend clears at completion.
  - if_flush in IDLE only blocks the fetch grant that cycle.
  - d_* traffic is never affected by if_flush.
- Store ack: d_ack on a store has d_rdata = mem_rdata (don't-care to the requester).
- Simultaneous events:
  - mem_ready together with if_flush in the final BUSY_I cycle: the ack is suppressed.
  - New requests arriving while BUSY are held off, with no ack, until IDLE.
- Protocol assertions (bench checks): mem_valid never drops without mem_ready, except on rst; if_ack and d_ack are never high together.

Decomposition:
- Shared package:
  - FSM state enum (IDLE/BUSY_I/BUSY_D).
  - Grant-owner encoding (GNT_I/GNT_D).
  - Default ADDR_W/DATA_W constants shared with the Memory interface.
- One natural sub-module, arb_priority_starve: combinational priority pick plus the registered starve_cnt. It has inputs req_i/req_d/grant_en and outputs gnt_i/gnt_d. The top holds the FSM, request register and response register.

Test Plan:
- Single fetch, if_addr=0x100, mem_ready on first valid cycle, mem_rdata=0x00500093 -> mem_valid at cycle 1, if_ack with if_rdata=0x00500093 at cycle 2, then IDLE.
- d_req and if_req both high from cycle 0, d_req re-asserted continuously, STARVE_LIMIT=3 -> grant order D,D,D,I; starve_cnt reads 3 before the fetch grant and 0 after.
- Store d_addr=0x2004, d_wdata=0xDEADBEEF, d_wstrb=4'b0011, mem_ready after 4 wait cycles -> mem_* fields stable for all 5 valid cycles, d_ack exactly once, no if_ack.
- Fetch in flight, if_flush pulsed in cycle 2, mem_ready in cycle 4 -> no if_ack; the next fetch, to 0x200, is granted in cycle 5 and acked normally.
- rst asserted asynchronously mid-BUSY_D (between edges) -> mem_valid, d_ack and starve_cnt go to 0 immediately; after release a fresh d_req is acked normally.
- Held if_req across its own ack cycle -> no duplicate grant; one mem_valid transaction per request.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, grant owner
// encoding and default bus widths shared with the memory interface.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } gnt_owner_t;

endpackage

// File: rtl/arb_priority_starve.sv
// Data-first priority pick between fetch and data requesters, with a
// saturating starvation counter that forces a fetch grant after a data streak.
module arb_priority_starve #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic grant_en,
    output logic gnt_i,
    output logic gnt_d
);

    logic [3:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt >= 4'(STARVE_LIMIT));
    assign gnt_d   = grant_en && req_d && (!req_i || !starved);
    assign gnt_i   = grant_en && req_i && (!req_d || starved);

    // Only counts data grants that actually bypassed a waiting fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (gnt_i)
            starve_cnt <= '0;
        else if (gnt_d && req_i && !starved)
            starve_cnt <= starve_cnt + 4'd1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency single-port memory between instruction
// fetch and load/store, with fetch flush and starvation-free fetch progress.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state, state_nxt;
    gnt_owner_t owner;
    logic       req_i, req_d, gnt_i, gnt_d, done, flush_pend;

    // A requester whose ack is out this cycle is still holding the old
    // request; masking it stops the same request being granted twice.
    assign req_i = if_req && !if_ack && !if_flush;
    assign req_d = d_req && !d_ack;
    assign done  = (state != IDLE) && mem_ready;
    assign owner = gnt_d ? GNT_D : GNT_I;

    arb_priority_starve #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .req_d   (req_d),
        .grant_en(state == IDLE),
        .gnt_i   (gnt_i),
        .gnt_d   (gnt_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt_d)
                    state_nxt = BUSY_D;
                else if (gnt_i)
                    state_nxt = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (gnt_i || gnt_d) begin
            mem_valid <= 1'b1;
            if (owner == GNT_D) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_wstrb;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end
        end else if (done) begin
            mem_valid <= 1'b0;
        end
    end

    // A flushed fetch still finishes on the memory side; only its ack is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            flush_pend <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            if (done) begin
                flush_pend <= 1'b0;
                if (state == BUSY_I) begin
                    if_ack   <= !(flush_pend || if_flush);
                    if_rdata <= mem_rdata;
                end else begin
                    d_ack   <= 1'b1;
                    d_rdata <= mem_rdata;
                end
            end else if (state == BUSY_I && if_flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a transaction-level reference predicts every memory
// request and every ack; a separate monitor pops and compares them.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int LIM = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, if_flush = 1'b0, if_ack;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0, d_we = 1'b0, d_ack;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0, d_rdata;
    logic [SW-1:0] d_wstrb = '0;
    logic          mem_valid, mem_we, mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata = '0;
    logic [SW-1:0] mem_wstrb;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            cyc;
    } req_t;

    typedef struct {
        logic          is_i;
        logic [DW-1:0] data;
        int            cyc;
    } ack_t;

    req_t req_q[$];
    ack_t ack_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_busy = 0;     // 0 none, 1 fetch owns the port, 2 data owns it
    int          m_cnt = 0;      // data grants taken past a waiting fetch
    int          m_wait = 0;     // memory wait cycles left before ready
    bit          m_fpend = 0, m_ack_i = 0, m_ack_d = 0;
    int          force_lat = -1;
    bit          force_rd = 0;
    logic [DW-1:0] force_rdata = '0;
    bit          drain = 0;
    bit          rst_evt = 0;

    function automatic logic [AW-1:0] new_addr();
        return AW'($urandom_range(0, 4095)) << 2;
    endfunction

    task automatic new_d();
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = new_addr();
        d_wdata = $urandom;
        d_wstrb = SW'($urandom_range(0, 15));
    endtask

    task automatic agents();
        if (m_ack_i) begin
            if (!drain && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1;
                if ($urandom_range(0, 1) == 1) if_addr = new_addr();
            end else if_req = 1'b0;
        end else if (!if_req && !drain && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = new_addr();
        end
        if_flush = !drain && ($urandom_range(0, 11) == 0);
        if (if_flush && if_req) if_addr = new_addr();
        if (m_ack_d) begin
            if (!drain && $urandom_range(0, 2) != 0) new_d();
            else d_req = 1'b0;
        end else if (!d_req && !drain && $urandom_range(0, 1) == 0) new_d();
    endtask

    task automatic mem_drive();
        mem_ready = (m_busy != 0) && (m_wait == 0);
        mem_rdata = force_rd ? force_rdata : $urandom;
    endtask

    task automatic model_step();
        bit fi, dq, gi, gd;
        bit nai = 0, nad = 0;
        if (m_busy == 0) begin
            fi = if_req && !m_ack_i && !if_flush;
            dq = d_req && !m_ack_d;
            gd = dq && (!fi || m_cnt < LIM);
            gi = fi && !gd;
            if (gd) begin
                if (fi) m_cnt = m_cnt + 1;
                req_q.push_back('{d_we, d_addr, d_wdata, d_wstrb, cyc + 1});
                m_busy = 2;
            end else if (gi) begin
                m_cnt = 0;
                req_q.push_back('{1'b0, if_addr, DW'(0), SW'(0), cyc + 1});
                m_busy = 1;
            end
            if (gd || gi) begin
                m_wait  = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
                m_fpend = 0;
            end
        end else begin
            if (m_busy == 1 && if_flush) m_fpend = 1;
            if (mem_ready) begin
                if (m_busy == 2) begin
                    ack_q.push_back('{1'b0, mem_rdata, cyc + 1});
                    nad = 1;
                end else if (!m_fpend) begin
                    ack_q.push_back('{1'b1, mem_rdata, cyc + 1});
                    nai = 1;
                end
                m_busy = 0;
            end else m_wait = m_wait - 1;
        end
        m_ack_i = nai;
        m_ack_d = nad;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic eval();
        mem_drive();
        model_step();
    endtask

    // ---------------- monitor ----------------
    req_t r;
    ack_t a;
    logic mv_prev = 1'b0, rdy_prev = 1'b0;
    logic s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;

    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (mem_valid && !mv_prev) begin
                if (req_q.size() == 0) chk(0, "unexpected_mem_req", mem_addr, 0);
                else begin
                    r = req_q.pop_front();
                    chk(cyc == r.cyc, "req_cycle", cyc, r.cyc);
                    chk(mem_addr === r.addr, "req_addr", mem_addr, r.addr);
                    chk(mem_we === r.we, "req_we", 32'(mem_we), 32'(r.we));
                    if (r.we) begin
                        chk(mem_wdata === r.wdata, "req_wdata", mem_wdata, r.wdata);
                        chk(mem_wstrb === r.wstrb, "req_wstrb", 32'(mem_wstrb), 32'(r.wstrb));
                    end
                end
            end else if (mem_valid && mv_prev) begin
                chk(mem_addr === s_addr && mem_we === s_we && mem_wdata === s_wdata &&
                    mem_wstrb === s_wstrb, "req_stable", mem_addr, s_addr);
            end
            if (mv_prev && !mem_valid && !rst_evt)
                chk(rdy_prev === 1'b1, "valid_drop_without_ready", 32'(rdy_prev), 1);
            if (if_ack || d_ack) begin
                chk(!(if_ack && d_ack), "acks_exclusive", 32'({if_ack, d_ack}), 0);
                if (ack_q.size() == 0) chk(0, "unexpected_ack", 32'({if_ack, d_ack}), 0);
                else begin
                    a = ack_q.pop_front();
                    chk(cyc == a.cyc, "ack_cycle", cyc, a.cyc);
                    chk(if_ack === a.is_i && d_ack === !a.is_i, "ack_port",
                        32'({if_ack, d_ack}), 32'({a.is_i, !a.is_i}));
                    chk((a.is_i ? if_rdata : d_rdata) === a.data, "ack_rdata",
                        a.is_i ? if_rdata : d_rdata, a.data);
                end
            end
            while (req_q.size() > 0 && req_q[0].cyc < cyc) begin
                chk(0, "missing_mem_req", 0, req_q[0].addr);
                void'(req_q.pop_front());
            end
            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                chk(0, "missing_ack", 0, ack_q[0].data);
                void'(ack_q.pop_front());
            end
            mv_prev  = mem_valid;
            rdy_prev = mem_ready;
            s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata; s_wstrb = mem_wstrb;
        end else begin
            mv_prev  = 1'b0;
            rdy_prev = 1'b0;
        end
        rst_evt = 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        adv();
        adv();
        chk(mem_valid === 1'b0, "rst_mem_valid", 32'(mem_valid), 0);
        chk(mem_we === 1'b0, "rst_mem_we", 32'(mem_we), 0);
        chk(mem_addr === '0, "rst_mem_addr", mem_addr, 0);
        chk(mem_wdata === '0, "rst_mem_wdata", mem_wdata, 0);
        chk(mem_wstrb === '0, "rst_mem_wstrb", 32'(mem_wstrb), 0);
        chk(if_ack === 1'b0, "rst_if_ack", 32'(if_ack), 0);
        chk(d_ack === 1'b0, "rst_d_ack", 32'(d_ack), 0);
        chk(if_rdata === '0, "rst_if_rdata", if_rdata, 0);
        chk(d_rdata === '0, "rst_d_rdata", d_rdata, 0);
        rst = 1'b0;

        // single fetch, ready on first valid cycle
        adv(); if_req = 1'b1; if_addr = 32'h100; force_lat = 0;
        force_rd = 1; force_rdata = 32'h00500093; eval();
        repeat (4) begin adv(); if (m_ack_i) if_req = 1'b0; eval(); end
        force_rd = 0;

        // store with four memory wait cycles
        adv(); new_d(); d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
        d_wstrb = 4'b0011; force_lat = 4; eval();
        repeat (8) begin adv(); if (m_ack_d) d_req = 1'b0; eval(); end

        // fetch cancelled while in flight, then redirected fetch to 0x200
        adv(); if_req = 1'b1; if_addr = 32'h180; force_lat = 2; eval();
        adv(); eval();
        adv(); if_flush = 1'b1; if_addr = 32'h200; eval();
        adv(); if_flush = 1'b0; force_lat = 0; eval();
        repeat (5) begin adv(); if (m_ack_i) if_req = 1'b0; eval(); end

        // randomized contention, flushes and random memory latency
        force_lat = -1;
        repeat (3000) begin adv(); agents(); eval(); end

        drain = 1;
        for (int i = 0; i < 300 && (if_req || d_req || m_busy != 0 || m_ack_i || m_ack_d); i++) begin
            adv(); agents(); eval();
        end
        chk(!(if_req || d_req || m_busy != 0), "drain_done", 32'({if_req, d_req}), 0);

        // asynchronous reset in the middle of a data transfer
        adv(); if_flush = 1'b0; mem_ready = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        req_q.push_back('{1'b0, 32'h300, DW'(0), SW'(0), cyc + 1});
        adv();
        #2; rst = 1'b1; rst_evt = 1; #1;
        chk(mem_valid === 1'b0, "async_rst_mem_valid", 32'(mem_valid), 0);
        chk(d_ack === 1'b0, "async_rst_d_ack", 32'(d_ack), 0);
        chk(mem_addr === '0, "async_rst_mem_addr", mem_addr, 0);
        adv(); rst = 1'b0;
        req_q.push_back('{1'b0, 32'h300, DW'(0), SW'(0), cyc + 1});
        adv(); mem_ready = 1'b1; mem_rdata = 32'h12345678;
        ack_q.push_back('{1'b0, 32'h12345678, cyc + 1});
        adv(); mem_ready = 1'b0; d_req = 1'b0;
        repeat (3) adv();

        chk(req_q.size() == 0, "req_queue_empty", req_q.size(), 0);
        chk(ack_q.size() == 0, "ack_queue_empty", ack_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
